// File: rtl/bnn_io_framer.sv
// bnn_io_framer: routes host weight/map words to the BNN banks and serialises the result label
module bnn_io_framer #(
  parameter int DW = 16,
  parameter int N_W1 = 6,
  parameter int N_W2 = 60,
  parameter int N_MAP = 136,
  parameter int LABEL_W = 4,
  parameter int OUT_W = 2,
  parameter int W_BITREV = 1,
  localparam int NWM = N_W1 > N_W2 ? N_W1 : N_W2,
  localparam int AW = NWM > 1 ? $clog2(NWM) : 1,
  localparam int MAW = N_MAP > 1 ? $clog2(N_MAP) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_port,
  input  logic [DW-1:0]      data_in_port,
  input  logic               in_valid_port,
  output logic               in_ready_port,
  output logic               w_we,
  output logic               w_bank,
  output logic [AW-1:0]      w_addr,
  output logic [DW-1:0]      w_data,
  output logic               m_we,
  output logic [MAW-1:0]     m_addr,
  output logic [DW-1:0]      m_data,
  output logic               frame_start,
  input  logic               res_valid,
  input  logic [LABEL_W-1:0] res_label,
  output logic               out_en_port,
  output logic [OUT_W-1:0]   data_out_port,
  output logic               wts_loaded,
  output logic               err
);
  localparam int NWT = N_W1 + N_W2;
  localparam int WCW = NWT > 1 ? $clog2(NWT) : 1;
  localparam int NB = (LABEL_W + OUT_W - 1) / OUT_W;
  localparam int SW = NB * OUT_W;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_RES, SEND} state_t;
  state_t state, nxt;
  logic [WCW-1:0] wc;
  logic [MAW-1:0] mc;
  logic [CW-1:0] bc;
  logic [SW-1:0] sr;
  logic [DW-1:0] rev;
  logic acc, w_acc, m_acc, m_drop, w_last, m_last, b_last, in_fc;
  for (genvar i = 0; i < DW; i++) begin : g_rev
    assign rev[i] = data_in_port[DW-1-i];
  end
  assign in_ready_port = state == IDLE;
  assign acc = in_valid_port & in_ready_port;
  assign w_acc = acc & mode_port;
  assign m_acc = acc & ~mode_port & wts_loaded;
  assign m_drop = acc & ~mode_port & ~wts_loaded;
  assign w_last = wc == WCW'(NWT - 1);
  assign m_last = mc == MAW'(N_MAP - 1);
  assign b_last = bc == CW'(NB - 1);
  assign in_fc = wc >= WCW'(N_W1);
  assign out_en_port = state == SEND;
  assign data_out_port = out_en_port ? sr[SW-1 -: OUT_W] : '0;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = (m_acc && m_last) ? WAIT_RES :
          (state == WAIT_RES && res_valid) ? SEND :
          (state == SEND && b_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wc <= '0;
      mc <= '0;
      bc <= '0;
      sr <= '0;
      w_we <= 1'b0;
      w_bank <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      frame_start <= 1'b0;
      wts_loaded <= 1'b0;
      err <= 1'b0;
    end else begin
      w_we <= w_acc;
      m_we <= m_acc;
      frame_start <= m_acc & m_last;
      if (w_acc) begin
        w_bank <= in_fc;
        w_addr <= AW'(in_fc ? wc - WCW'(N_W1) : wc);
        w_data <= W_BITREV != 0 ? rev : data_in_port;
        wc <= w_last ? '0 : wc + 1'b1;
        if (w_last) wts_loaded <= 1'b1;
        if (mc != '0) begin
          mc <= '0;
          err <= 1'b1;
        end
      end
      if (m_acc) begin
        m_addr <= mc;
        m_data <= data_in_port;
        mc <= m_last ? '0 : mc + 1'b1;
      end
      if (m_drop || (res_valid && state != WAIT_RES)) err <= 1'b1;
      if (state == WAIT_RES && res_valid) begin
        sr <= SW'(res_label);
        bc <= '0;
      end else if (state == SEND) begin
        sr <= sr << OUT_W;
        bc <= bc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bnn_io_framer.sv
// tb_bnn_io_framer: scoreboard bench for weight/map routing and label serialisation
module tb_bnn_io_framer;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, vin = 1'b0, res_valid = 1'b0;
  logic [15:0] din = '0;
  logic [3:0] lab0 = '0;
  logic [4:0] lab1 = '0;
  logic rdy0, w_we, w_bank, m_we, fs, oe0, wl0, err0;
  logic [5:0] w_addr;
  logic [15:0] w_data, m_data;
  logic [7:0] m_addr;
  logic [1:0] do0;
  logic rdy1, w_we1, w_bank1, m_we1, fs1, oe1, wl1, err1;
  logic [5:0] w_addr1;
  logic [15:0] w_data1, m_data1;
  logic [7:0] m_addr1;
  logic [1:0] do1;
  int errors = 0, checks = 0;
  logic [63:0] wq[$], mq[$];
  logic [1:0] oq0[$], oq1[$];
  int wc = 0, mc = 0;
  bit loaded = 0, mon = 0;

  bnn_io_framer u0 (
    .clk(clk), .rst(rst), .mode_port(mode), .data_in_port(din), .in_valid_port(vin),
    .in_ready_port(rdy0), .w_we(w_we), .w_bank(w_bank), .w_addr(w_addr), .w_data(w_data),
    .m_we(m_we), .m_addr(m_addr), .m_data(m_data), .frame_start(fs), .res_valid(res_valid),
    .res_label(lab0), .out_en_port(oe0), .data_out_port(do0), .wts_loaded(wl0), .err(err0)
  );

  bnn_io_framer #(.LABEL_W(5), .OUT_W(2)) u1 (
    .clk(clk), .rst(rst), .mode_port(mode), .data_in_port(din), .in_valid_port(vin),
    .in_ready_port(rdy1), .w_we(w_we1), .w_bank(w_bank1), .w_addr(w_addr1), .w_data(w_data1),
    .m_we(m_we1), .m_addr(m_addr1), .m_data(m_data1), .frame_start(fs1), .res_valid(res_valid),
    .res_label(lab1), .out_en_port(oe1), .data_out_port(do1), .wts_loaded(wl1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[15-i];
    return r;
  endfunction

  task automatic reset_model;
    wc = 0;
    mc = 0;
    loaded = 0;
  endtask

  task automatic send(input bit m, input logic [15:0] d);
    int n = 0;
    bit b, f;
    logic [5:0] a;
    @(negedge clk);
    mode = m;
    din = d;
    vin = 1'b1;
    while (!(rdy0 && rdy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) chk("ready_timeout", 64'd0, 64'd1);
    if (m) begin
      b = wc >= 6;
      a = 6'(b ? wc - 6 : wc);
      wq.push_back(64'({b, a, rev16(d)}));
      if (mc != 0) mc = 0;
      wc++;
      if (wc == 66) begin
        wc = 0;
        loaded = 1;
      end
    end else if (loaded) begin
      f = mc == 135;
      mq.push_back(64'({f, 8'(mc), d}));
      mc = f ? 0 : mc + 1;
    end
    @(posedge clk);
    #1 vin = 1'b0;
  endtask

  task automatic load_weights;
    logic [15:0] d;
    for (int i = 0; i < 66; i++) begin
      d = i == 0 ? 16'h8001 : i == 6 ? 16'h0003 : 16'($urandom);
      send(1'b1, d);
      if (i == 64) chk("wl_before_last", 64'(wl0), 64'd0);
    end
    chk("wl_after_last", 64'(wl0), 64'd1);
  endtask

  task automatic load_map(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 16'($urandom));
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (mon) begin
      if (w_we) begin
        if (wq.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
        else begin
          e = wq.pop_front();
          chk("w_write", 64'({w_bank, w_addr, w_data}), e);
        end
      end
      if (m_we) begin
        if (mq.size() == 0) chk("m_unexpected", 64'd1, 64'd0);
        else begin
          e = mq.pop_front();
          chk("m_write", 64'({fs, m_addr, m_data}), e);
          if (fs) chk("rdy_at_frame_start", 64'(rdy0), 64'd0);
        end
      end else if (fs) chk("fs_without_m_we", 64'd1, 64'd0);
      if (oe0) begin
        if (oq0.size() == 0) chk("beat0_unexpected", 64'd1, 64'd0);
        else chk("beat0", 64'(do0), 64'(oq0.pop_front()));
      end else chk("dout0_idle", 64'(do0), 64'd0);
      if (oe1) begin
        if (oq1.size() == 0) chk("beat1_unexpected", 64'd1, 64'd0);
        else chk("beat1", 64'(do1), 64'(oq1.pop_front()));
      end else chk("dout1_idle", 64'(do1), 64'd0);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_w_we", 64'(w_we), 64'd0);
    chk("rst_m_we", 64'(m_we), 64'd0);
    chk("rst_fs", 64'(fs), 64'd0);
    chk("rst_out_en", 64'(oe0), 64'd0);
    chk("rst_dout", 64'(do0), 64'd0);
    chk("rst_wl", 64'(wl0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    mon = 1;
    rst = 1'b0;
    send(1'b0, 16'h1234);
    repeat (2) @(negedge clk);
    chk("err_map_no_wts", 64'(err0), 64'd1);
    chk("wl_still_0", 64'(wl0), 64'd0);
    do_reset();
    chk("err_cleared", 64'(err0), 64'd0);
    load_weights();
    chk("err_after_wts", 64'(err0), 64'd0);
    load_map(136);
    @(negedge clk);
    chk("rdy_wait_res", 64'(rdy0), 64'd0);
    mode = 1'b0;
    din = 16'hBEEF;
    vin = 1'b1;
    repeat (4) @(negedge clk);
    vin = 1'b0;
    chk("err_hold_busy", 64'(err0), 64'd0);
    res_valid = 1'b1;
    lab0 = 4'h9;
    lab1 = 5'h13;
    oq0.push_back(2'b10);
    oq0.push_back(2'b01);
    oq1.push_back(2'b01);
    oq1.push_back(2'b00);
    oq1.push_back(2'b11);
    @(negedge clk);
    res_valid = 1'b0;
    chk("send_beat0_oe", 64'(oe0), 64'd1);
    chk("send_beat0_rdy", 64'(rdy0), 64'd0);
    @(negedge clk);
    chk("send_beat1_rdy", 64'(rdy0), 64'd0);
    @(negedge clk);
    chk("rdy_after_send", 64'(rdy0), 64'd1);
    chk("oe_after_send", 64'(oe0), 64'd0);
    chk("l5_beat2_oe", 64'(oe1), 64'd1);
    @(negedge clk);
    chk("l5_rdy_after_send", 64'(rdy1), 64'd1);
    chk("beats0_drained", 64'(oq0.size()), 64'd0);
    chk("beats1_drained", 64'(oq1.size()), 64'd0);
    chk("err_after_send", 64'(err0), 64'd0);
    load_map(40);
    send(1'b1, 16'hA5A5);
    send(1'b0, 16'h0F0F);
    repeat (2) @(negedge clk);
    chk("err_partial_frame", 64'(err0), 64'd1);
    chk("partial_writes_done", 64'(mq.size() + wq.size()), 64'd0);
    do_reset();
    chk("wl_reset", 64'(wl0), 64'd0);
    @(negedge clk);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    chk("err_stray_res", 64'(err0), 64'd1);
    do_reset();
    load_weights();
    load_map(136);
    @(negedge clk);
    res_valid = 1'b1;
    lab0 = 4'h9;
    lab1 = 5'h13;
    oq0.push_back(2'b10);
    oq0.push_back(2'b01);
    oq1.push_back(2'b01);
    oq1.push_back(2'b00);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    chk("rst_send_oe", 64'(oe0), 64'd0);
    chk("rst_send_rdy", 64'(rdy0), 64'd1);
    chk("rst_send_wl", 64'(wl0), 64'd0);
    chk("rst_send_oe_l5", 64'(oe1), 64'd0);
    send(1'b0, 16'h5555);
    repeat (2) @(negedge clk);
    chk("err_map_after_rst", 64'(err0), 64'd1);
    chk("queues_empty", 64'(mq.size() + wq.size() + oq0.size() + oq1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
